operand_stack: RTL and testbench

- Parametrised LIFO operand stack for the stack-ALU datapath. Successor to the fixed 16x32 stack.
- Accepts one push per cycle and pops 1 or 2 operands per handshake.
- Supports same-cycle pop+push ("replace"), so the ALU can consume two operands and write back its result in one cycle.
- Exposes the top two entries combinationally, plus fill level and status flags.

---
 rtl/operand_stack_if.sv | 31 +++
 rtl/operand_stack.sv | 77 +++++++
 tb/tb_operand_stack.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/operand_stack_if.sv
// operand_stack_if: push/pop handshake bundle for the operand stack.
// The master modport is the producer/consumer side; slave is the stack.
interface operand_stack_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
);
    logic              PUSH_STB;
    logic [DATA_W-1:0] PUSH_DAT;
    logic              PUSH_ACK;
    logic [1:0]        POP_CNT;
    logic              POP_STB;
    logic              POP_ACK;
    logic [DATA_W-1:0] POP_DAT_A;
    logic [DATA_W-1:0] POP_DAT_B;
    logic [LVL_W-1:0]  LEVEL;
    logic              EMP;
    logic              FULL;
    logic              ERR;
    logic              ERR_CLR;

    modport master (
        output PUSH_STB, PUSH_DAT, POP_CNT, POP_ACK, ERR_CLR,
        input  PUSH_ACK, POP_STB, POP_DAT_A, POP_DAT_B, LEVEL, EMP, FULL, ERR
    );

    modport slave (
        input  PUSH_STB, PUSH_DAT, POP_CNT, POP_ACK, ERR_CLR,
        output PUSH_ACK, POP_STB, POP_DAT_A, POP_DAT_B, LEVEL, EMP, FULL, ERR
    );
endinterface

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack with 1/2-operand pop, same-cycle replace and
// combinational TOS/NOS. Define OPERAND_STACK_ERR_EN for the sticky misuse flag.
module operand_stack #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int LVL_W  = $clog2(DEPTH) + 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input logic           CLK,
    input logic           RST,
    operand_stack_if.slave bus
);
    logic [LVL_W-1:0]  r_level;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        w_pop_n;
    logic              w_pop_stb;
    logic              w_pop_fire;
    logic              w_push_ack;
    logic [LVL_W-1:0]  w_base;
    logic [LVL_W-1:0]  w_tos;
    logic [LVL_W-1:0]  w_nos;

    // Pop is applied before push, so a replace writes at the post-pop level.
    always_comb begin
        w_pop_n    = (bus.POP_CNT == 2'd1 || bus.POP_CNT == 2'd2) ? bus.POP_CNT : 2'd0;
        w_pop_stb  = (w_pop_n != 2'd0) && (r_level >= LVL_W'(w_pop_n));
        w_pop_fire = w_pop_stb && bus.POP_ACK;
        w_push_ack = bus.PUSH_STB && ((r_level < LVL_W'(DEPTH)) || w_pop_fire);
        w_base     = r_level - (w_pop_fire ? LVL_W'(w_pop_n) : LVL_W'(0));
        w_tos      = r_level - LVL_W'(1);
        w_nos      = r_level - LVL_W'(2);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_level <= '0;
        else
            r_level <= w_base + LVL_W'(w_push_ack);
    end

    always_ff @(posedge CLK) begin
        if (w_push_ack && !RST)
            r_mem[w_base[AW-1:0]] <= bus.PUSH_DAT;
    end

    assign bus.PUSH_ACK  = w_push_ack;
    assign bus.POP_STB   = w_pop_stb;
    assign bus.POP_DAT_A = (r_level >= LVL_W'(1)) ? r_mem[w_tos[AW-1:0]] : '0;
    assign bus.POP_DAT_B = (r_level >= LVL_W'(2)) ? r_mem[w_nos[AW-1:0]] : '0;
    assign bus.LEVEL     = r_level;
    assign bus.EMP       = (r_level == '0);
    assign bus.FULL      = (r_level == LVL_W'(DEPTH));

`ifdef OPERAND_STACK_ERR_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = (bus.PUSH_STB && !w_push_ack) ||
                       (bus.POP_ACK && (w_pop_n != 2'd0) && !w_pop_stb);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
        else if (bus.ERR_CLR)
            r_err <= 1'b0;
    end

    assign bus.ERR = r_err;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = bus.ERR_CLR;
    assign bus.ERR          = 1'b0;
`endif
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed vector table plus randomized traffic against a queue model.
module tb_operand_stack;
    localparam int DW = 32;
    localparam int DP = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    operand_stack_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
    operand_stack #(.DATA_W(DW), .DEPTH(DP)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];
    logic m_err = 1'b0;

    typedef struct {
        logic        ps;
        logic [31:0] pd;
        logic [1:0]  pc;
        logic        pa;
        logic        ec;
        logic        x_ack;
        logic        x_stb;
        int          x_lvl;
        logic [31:0] x_a;
        logic [31:0] x_b;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input logic ps, input logic [31:0] pd, input logic [1:0] pc,
                        input logic pa, input logic ec, output logic ack, output logic stb);
        int n;
        logic m_stb, m_ack, set;
        logic [31:0] ea, eb;
        bus.PUSH_STB = ps;
        bus.PUSH_DAT = pd;
        bus.POP_CNT  = pc;
        bus.POP_ACK  = pa;
        bus.ERR_CLR  = ec;
        #1;
        n     = (pc == 2'd1 || pc == 2'd2) ? int'(pc) : 0;
        m_stb = (n != 0) && (q.size() >= n);
        m_ack = ps && ((q.size() < DP) || (m_stb && pa));
        ea = 0;
        eb = 0;
        if (q.size() >= 1) ea = q[q.size()-1];
        if (q.size() >= 2) eb = q[q.size()-2];
        chk("push_ack", 32'(bus.PUSH_ACK), 32'(m_ack));
        chk("pop_stb", 32'(bus.POP_STB), 32'(m_stb));
        chk("tos", bus.POP_DAT_A, ea);
        chk("nos", bus.POP_DAT_B, eb);
        chk("level", 32'(bus.LEVEL), 32'(q.size()));
        chk("emp", 32'(bus.EMP), 32'(q.size() == 0));
        chk("full", 32'(bus.FULL), 32'(q.size() == DP));
        chk("err", 32'(bus.ERR), 32'(m_err));
        ack = bus.PUSH_ACK;
        stb = bus.POP_STB;
        @(posedge CLK);
        set = (ps && !m_ack) || (pa && n != 0 && !m_stb);
`ifdef OPERAND_STACK_ERR_EN
        m_err = set ? 1'b1 : (ec ? 1'b0 : m_err);
`else
        m_err = 1'b0 & set;
`endif
        if (m_stb && pa) repeat (n) void'(q.pop_back());
        if (m_ack) q.push_back(pd);
        @(negedge CLK);
    endtask

    initial begin
        logic ack, stb;
        vt[0]  = '{1, 32'h11, 0, 0, 0, 1, 0, 1, 32'h11, 32'h0};
        vt[1]  = '{1, 32'h22, 0, 0, 0, 1, 0, 2, 32'h22, 32'h11};
        vt[2]  = '{1, 32'h33, 0, 0, 0, 1, 0, 3, 32'h33, 32'h22};
        vt[3]  = '{1, 32'h44, 0, 0, 0, 1, 0, 4, 32'h44, 32'h33};
        vt[4]  = '{1, 32'h55, 0, 0, 0, 0, 0, 4, 32'h44, 32'h33};
        vt[5]  = '{0, 32'h0,  0, 0, 1, 0, 0, 4, 32'h44, 32'h33};
        vt[6]  = '{1, 32'h77, 2, 1, 0, 1, 1, 3, 32'h77, 32'h22};
        vt[7]  = '{0, 32'h0,  2, 1, 0, 0, 1, 1, 32'h11, 32'h0};
        vt[8]  = '{0, 32'h0,  2, 1, 0, 0, 0, 1, 32'h11, 32'h0};
        vt[9]  = '{0, 32'h0,  1, 1, 0, 0, 1, 0, 32'h0,  32'h0};
        vt[10] = '{1, 32'h10, 0, 0, 0, 1, 0, 1, 32'h10, 32'h0};
        vt[11] = '{1, 32'h20, 0, 0, 0, 1, 0, 2, 32'h20, 32'h10};
        vt[12] = '{1, 32'hAA, 1, 1, 0, 1, 1, 2, 32'hAA, 32'h10};
        vt[13] = '{0, 32'h0,  3, 1, 0, 0, 0, 2, 32'hAA, 32'h10};
        vt[14] = '{1, 32'h30, 0, 0, 0, 1, 0, 3, 32'h30, 32'hAA};
        vt[15] = '{1, 32'h40, 0, 0, 0, 1, 0, 4, 32'h40, 32'h30};
        vt[16] = '{1, 32'hBB, 1, 1, 0, 1, 1, 4, 32'hBB, 32'h30};

        bus.PUSH_STB = 0;
        bus.PUSH_DAT = 0;
        bus.POP_CNT  = 0;
        bus.POP_ACK  = 0;
        bus.ERR_CLR  = 0;
        repeat (2) @(negedge CLK);
        chk("rst level", 32'(bus.LEVEL), 0);
        chk("rst emp", 32'(bus.EMP), 1);
        chk("rst full", 32'(bus.FULL), 0);
        chk("rst err", 32'(bus.ERR), 0);
        RST = 0;
        @(negedge CLK);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].ps, vt[i].pd, vt[i].pc, vt[i].pa, vt[i].ec, ack, stb);
            chk($sformatf("v%0d ack", i), 32'(ack), 32'(vt[i].x_ack));
            chk($sformatf("v%0d stb", i), 32'(stb), 32'(vt[i].x_stb));
            chk($sformatf("v%0d level", i), 32'(bus.LEVEL), 32'(vt[i].x_lvl));
            chk($sformatf("v%0d tos", i), bus.POP_DAT_A, vt[i].x_a);
            chk($sformatf("v%0d nos", i), bus.POP_DAT_B, vt[i].x_b);
        end

        step(0, 0, 1, 1, 0, ack, stb);
        chk("pre-rst level", 32'(bus.LEVEL), 3);
        bus.PUSH_STB = 1;
        bus.PUSH_DAT = 32'hDEAD;
        #2 RST = 1;
        #1;
        chk("arst level", 32'(bus.LEVEL), 0);
        chk("arst emp", 32'(bus.EMP), 1);
        chk("arst full", 32'(bus.FULL), 0);
        chk("arst err", 32'(bus.ERR), 0);
        q.delete();
        m_err = 1'b0;
        bus.PUSH_STB = 0;
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);

        repeat (400) begin
            step($urandom_range(0, 9) < 6, $urandom, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, ack, stb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
